// File: rtl/lynx_kbd_pkg.sv
// Shared definitions for the Lynx keyboard matrix: scancode prefixes,
// prefix-tracking FSM states, matrix geometry and the keymap entry type.
package lynx_kbd_pkg;

  // PS/2 prefix and special codes
  localparam logic [7:0] KC_EXT   = 8'hE0;
  localparam logic [7:0] KC_BRK   = 8'hF0;
  localparam logic [7:0] KC_PAUSE = 8'hE1;
  localparam logic [7:0] KC_BAT   = 8'hAA;
  localparam logic [7:0] KC_OVR0  = 8'h00;
  localparam logic [7:0] KC_OVR1  = 8'hFF;

  // Matrix geometry
  localparam int MATRIX_ROWS = 10;
  localparam int MATRIX_COLS = 8;
  localparam int ROW_W       = 4;
  localparam int BIT_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXTBRK,
    ST_SKIP
  } kbd_state_e;

  // One keymap lookup result
  typedef struct packed {
    logic             hit;
    logic [ROW_W-1:0] row;
    logic [BIT_W-1:0] col_bit;
  } keymap_t;

  // Codes that wipe the whole matrix when seen outside a prefix sequence
  function automatic logic is_clear_code(input logic [7:0] code);
    return (code == KC_BAT) || (code == KC_OVR0) || (code == KC_OVR1);
  endfunction

endpackage

// File: rtl/lynx_keymatrix_if.sv
// Scancode stream in, CPU row select in, column byte and any-key flag out.
interface lynx_keymatrix_if;
  logic       keyStrb;
  logic [7:0] keyCode;
  logic [3:0] row;
  logic [7:0] col;
  logic       anyKey;

  modport master (output keyStrb, output keyCode, output row,
                  input  col,     input  anyKey);
  modport slave  (input  keyStrb, input  keyCode, input  row,
                  output col,     output anyKey);
endinterface

// File: rtl/lynx_keymap_rom.sv
// Combinational PS/2 set-2 to Lynx matrix position table. {ext, code} selects
// an entry; anything not listed (including the E0 12 / E0 59 fake shifts) is
// a miss.
module lynx_keymap_rom
  import lynx_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output keymap_t    key
);

  function automatic keymap_t km(input logic [ROW_W-1:0] r, input logic [BIT_W-1:0] b);
    return '{hit: 1'b1, row: r, col_bit: b};
  endfunction

  // Table lookup; default miss keeps the output fully assigned
  always_comb begin
    key = '0;
    case ({ext, code})
      // row 0: modifiers and top-left keys
      9'h0_12: key = km(4'd0, 3'd0);   // left shift
      9'h0_59: key = km(4'd0, 3'd0);   // right shift shares the shift bit
      9'h0_14: key = km(4'd0, 3'd1);   // ctrl
      9'h1_14: key = km(4'd0, 3'd1);   // right ctrl
      9'h0_58: key = km(4'd0, 3'd2);   // caps lock
      9'h0_76: key = km(4'd0, 3'd3);   // escape
      9'h0_16: key = km(4'd0, 3'd4);   // 1
      9'h0_1E: key = km(4'd0, 3'd5);   // 2
      // row 1
      9'h0_26: key = km(4'd1, 3'd0);   // 3
      9'h0_25: key = km(4'd1, 3'd1);   // 4
      9'h0_2E: key = km(4'd1, 3'd2);   // 5
      9'h0_15: key = km(4'd1, 3'd3);   // Q
      9'h0_1D: key = km(4'd1, 3'd4);   // W
      9'h0_24: key = km(4'd1, 3'd5);   // E
      9'h0_2D: key = km(4'd1, 3'd6);   // R
      9'h0_2C: key = km(4'd1, 3'd7);   // T
      // row 2
      9'h0_22: key = km(4'd2, 3'd0);   // X
      9'h0_1A: key = km(4'd2, 3'd1);   // Z
      9'h0_1C: key = km(4'd2, 3'd2);   // A
      9'h0_1B: key = km(4'd2, 3'd3);   // S
      9'h0_23: key = km(4'd2, 3'd4);   // D
      9'h0_2B: key = km(4'd2, 3'd5);   // F
      9'h0_21: key = km(4'd2, 3'd6);   // C
      9'h0_2A: key = km(4'd2, 3'd7);   // V
      // row 3
      9'h0_36: key = km(4'd3, 3'd0);   // 6
      9'h0_3D: key = km(4'd3, 3'd1);   // 7
      9'h0_35: key = km(4'd3, 3'd2);   // Y
      9'h0_3C: key = km(4'd3, 3'd3);   // U
      9'h0_34: key = km(4'd3, 3'd4);   // G
      9'h0_33: key = km(4'd3, 3'd5);   // H
      9'h0_32: key = km(4'd3, 3'd6);   // B
      9'h0_31: key = km(4'd3, 3'd7);   // N
      // row 4
      9'h0_3E: key = km(4'd4, 3'd0);   // 8
      9'h0_46: key = km(4'd4, 3'd1);   // 9
      9'h0_43: key = km(4'd4, 3'd2);   // I
      9'h0_44: key = km(4'd4, 3'd3);   // O
      9'h0_3B: key = km(4'd4, 3'd4);   // J
      9'h0_42: key = km(4'd4, 3'd5);   // K
      9'h0_3A: key = km(4'd4, 3'd6);   // M
      9'h0_41: key = km(4'd4, 3'd7);   // ,
      // row 5
      9'h0_45: key = km(4'd5, 3'd0);   // 0
      9'h0_4E: key = km(4'd5, 3'd1);   // -
      9'h0_4D: key = km(4'd5, 3'd2);   // P
      9'h0_54: key = km(4'd5, 3'd3);   // [
      9'h0_4B: key = km(4'd5, 3'd4);   // L
      9'h0_4C: key = km(4'd5, 3'd5);   // ;
      9'h0_49: key = km(4'd5, 3'd6);   // .
      9'h0_4A: key = km(4'd5, 3'd7);   // /
      // row 6
      9'h0_55: key = km(4'd6, 3'd0);   // =
      9'h0_5B: key = km(4'd6, 3'd1);   // ]
      9'h0_52: key = km(4'd6, 3'd2);   // '
      9'h0_5D: key = km(4'd6, 3'd3);   // backslash
      // row 7
      9'h0_66: key = km(4'd7, 3'd0);   // backspace (Lynx DEL)
      9'h0_0D: key = km(4'd7, 3'd1);   // tab
      // row 8
      9'h0_5A: key = km(4'd8, 3'd3);   // return
      9'h1_5A: key = km(4'd8, 3'd3);   // keypad enter doubles as return
      // row 9: space and cursor block
      9'h1_6B: key = km(4'd9, 3'd0);   // left
      9'h1_75: key = km(4'd9, 3'd1);   // up
      9'h1_72: key = km(4'd9, 3'd2);   // down
      9'h0_29: key = km(4'd9, 3'd3);   // space
      9'h1_74: key = km(4'd9, 3'd4);   // right
      9'h1_71: key = km(4'd9, 3'd5);   // delete
      default: key = '0;
    endcase
  end

endmodule

// File: rtl/lynx_keymatrix.sv
// PS/2 scancode stream to Lynx active-low keyboard matrix. Tracks E0/F0/E1
// prefixes, updates one matrix bit per key event and serves a registered
// column byte for the row the CPU selects.
module lynx_keymatrix
  import lynx_kbd_pkg::*;
#(
  parameter int ROWS       = MATRIX_ROWS,
  parameter int PAUSE_SKIP = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  lynx_keymatrix_if.slave  bus
);

  localparam int CNT_W = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);
  localparam logic [ROW_W:0] ROW_LIMIT = (ROW_W + 1)'(ROWS);

  kbd_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROWS-1:0][MATRIX_COLS-1:0] matrix_q;

  logic    strb;
  logic    lookup_ext;
  keymap_t key;
  logic    ev_valid;
  logic    ev_make;
  logic    clear_all;

  assign strb       = ce & bus.keyStrb;
  assign lookup_ext = (state_q == ST_EXT) || (state_q == ST_EXTBRK);

  lynx_keymap_rom u_rom (
    .ext  (lookup_ext),
    .code (bus.keyCode),
    .key  (key)
  );

  // Prefix FSM state and pause-skip counter register
  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (ce) begin
      if (!reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  // Next-state decode and key-event generation
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ev_valid  = 1'b0;
    ev_make   = 1'b0;
    clear_all = 1'b0;
    if (strb) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.keyCode == KC_BRK) begin
            state_d = ST_BRK;
          end else if (bus.keyCode == KC_EXT) begin
            state_d = ST_EXT;
          end else if (bus.keyCode == KC_PAUSE) begin
            state_d = ST_SKIP;
            cnt_d   = CNT_W'(PAUSE_SKIP);
          end else if (is_clear_code(bus.keyCode)) begin
            clear_all = 1'b1;
          end else begin
            ev_valid = key.hit;
            ev_make  = 1'b1;
          end
        end
        ST_EXT: begin
          if (bus.keyCode == KC_BRK) begin
            state_d = ST_EXTBRK;
          end else begin
            ev_valid = key.hit;
            ev_make  = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK, ST_EXTBRK: begin
          ev_valid = key.hit;
          state_d  = ST_IDLE;
        end
        ST_SKIP: begin
          // The byte that brings the count to zero is the last one swallowed
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Matrix image: make clears a bit, break sets it, clear codes set all
  // NOTE: the matrix is a small register array, not a RAM, so it is reset
  // explicitly; a released keyboard must read all ones from the first cycle.
  always_ff @(posedge clock) begin
    if (ce) begin
      if (!reset || clear_all) begin
        matrix_q <= '1;
      end else if (ev_valid && ({1'b0, key.row} < ROW_LIMIT)) begin
        matrix_q[key.row][key.col_bit] <= ~ev_make;
      end
    end
  end

  // Registered read port; sees the matrix as it was before this edge's update
  always_ff @(posedge clock) begin
    if (ce) begin
      if (!reset) begin
        bus.col    <= 8'hFF;
        bus.anyKey <= 1'b0;
      end else begin
        bus.col    <= ({1'b0, bus.row} < ROW_LIMIT) ? matrix_q[bus.row] : 8'hFF;
        bus.anyKey <= ~(&matrix_q);
      end
    end
  end

endmodule

// File: tb/tb_lynx_keymatrix.sv
// Self-checking bench for lynx_keymatrix: vector table plus hand sequences,
// expected column/any-key values queued at drive time and popped after the edge.
module tb_lynx_keymatrix;

  logic clock = 1'b0;
  logic reset;
  logic ce;

  always #5 clock = ~clock;

  lynx_keymatrix_if bus ();

  lynx_keymatrix dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  typedef struct {
    logic       strb;
    logic [7:0] code;
    logic [3:0] row;
    logic [7:0] exp_col;
    logic       exp_any;
  } vec_t;

  typedef struct {
    logic [7:0] col;
    logic       any;
    int         tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int tag,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, tag, act, exp);
    end
  endtask

  function automatic void add(input logic s, input logic [7:0] c, input logic [3:0] r,
                              input logic [7:0] ec, input logic ea);
    vecs.push_back('{s, c, r, ec, ea});
  endfunction

  // Drive one cycle of stimulus; expected values are for the edge that consumes it
  task automatic step(input logic s, input logic [7:0] c, input logic [3:0] r,
                      input logic [7:0] ec, input logic ea, input int tag);
    exp_t e;
    bus.keyStrb = s;
    bus.keyCode = c;
    bus.row     = r;
    sb.push_back('{ec, ea, tag});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("col", e.tag, bus.col, e.col);
    check("anyKey", e.tag, {7'b0, bus.anyKey}, {7'b0, e.any});
    bus.keyStrb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // make 1C then read row 2 (same-cycle read returns old value), break 1C
    add(1, 8'h1C, 2, 8'hFF, 0); add(0, 8'h00, 2, 8'hFB, 1);
    add(1, 8'hF0, 2, 8'hFB, 1); add(1, 8'h1C, 2, 8'hFB, 1); add(0, 8'h00, 2, 8'hFF, 0);
    // E0 75 make, plain 75 misses, E0 F0 75 breaks
    add(1, 8'hE0, 9, 8'hFF, 0); add(1, 8'h75, 9, 8'hFF, 0); add(0, 8'h00, 9, 8'hFD, 1);
    add(1, 8'h75, 9, 8'hFD, 1); add(0, 8'h00, 9, 8'hFD, 1);
    add(1, 8'hE0, 9, 8'hFD, 1); add(1, 8'hF0, 9, 8'hFD, 1); add(1, 8'h75, 9, 8'hFD, 1);
    add(0, 8'h00, 9, 8'hFF, 0);
    // pause sequence swallowed, then space makes and breaks
    add(1, 8'hE1, 0, 8'hFF, 0); add(1, 8'h14, 0, 8'hFF, 0); add(1, 8'h77, 0, 8'hFF, 0);
    add(1, 8'hE1, 0, 8'hFF, 0); add(1, 8'hF0, 0, 8'hFF, 0); add(1, 8'h14, 0, 8'hFF, 0);
    add(1, 8'hF0, 0, 8'hFF, 0); add(1, 8'h77, 0, 8'hFF, 0);
    add(1, 8'h29, 9, 8'hFF, 0); add(0, 8'h00, 9, 8'hF7, 1); add(0, 8'h00, 0, 8'hFF, 1);
    add(1, 8'hF0, 9, 8'hF7, 1); add(1, 8'h29, 9, 8'hF7, 1); add(0, 8'h00, 9, 8'hFF, 0);
    // hold shift and return, BAT clears both
    add(1, 8'h12, 0, 8'hFF, 0); add(1, 8'h5A, 8, 8'hFF, 1);
    add(0, 8'h00, 0, 8'hFE, 1); add(0, 8'h00, 8, 8'hF7, 1);
    add(1, 8'hAA, 0, 8'hFE, 1); add(0, 8'h00, 0, 8'hFF, 0); add(0, 8'h00, 8, 8'hFF, 0);
    // overrun codes FF and 00 also clear
    add(1, 8'h1C, 2, 8'hFF, 0); add(1, 8'hFF, 2, 8'hFB, 1); add(0, 8'h00, 2, 8'hFF, 0);
    add(1, 8'h29, 9, 8'hFF, 0); add(1, 8'h00, 9, 8'hF7, 1); add(0, 8'h00, 9, 8'hFF, 0);
    // both shifts on one bit: the later break wins
    add(1, 8'h12, 0, 8'hFF, 0); add(1, 8'h59, 0, 8'hFE, 1);
    add(1, 8'hF0, 0, 8'hFE, 1); add(1, 8'h12, 0, 8'hFE, 1); add(0, 8'h00, 0, 8'hFF, 0);
    // fake shifts E0 12 / E0 59 are ignored
    add(1, 8'hE0, 0, 8'hFF, 0); add(1, 8'h12, 0, 8'hFF, 0); add(0, 8'h00, 0, 8'hFF, 0);
    add(1, 8'hE0, 0, 8'hFF, 0); add(1, 8'h59, 0, 8'hFF, 0); add(0, 8'h00, 0, 8'hFF, 0);
    // typematic repeats are idempotent
    add(1, 8'h1C, 2, 8'hFF, 0);
    for (int i = 0; i < 4; i++) add(1, 8'h1C, 2, 8'hFB, 1);
    add(1, 8'hF0, 2, 8'hFB, 1); add(1, 8'h1C, 2, 8'hFB, 1); add(0, 8'h00, 2, 8'hFF, 0);

    reset       = 1'b0;
    ce          = 1'b1;
    bus.keyStrb = 1'b0;
    bus.keyCode = 8'h00;
    bus.row     = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_col", 0, bus.col, 8'hFF);
    check("reset_anyKey", 0, {7'b0, bus.anyKey}, 8'h00);
    reset = 1'b1;

    // row sweep over implemented and unimplemented rows
    for (int r = 0; r < 16; r++) step(1'b0, 8'h00, 4'(r), 8'hFF, 1'b0, 100 + r);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].strb, vecs[i].code, vecs[i].row, vecs[i].exp_col, vecs[i].exp_any, 200 + i);

    // ce low freezes everything, including a strobed make
    ce          = 1'b0;
    bus.keyStrb = 1'b1;
    bus.keyCode = 8'h1C;
    bus.row     = 4'd2;
    repeat (2) @(posedge clock);
    #1;
    ce = 1'b1;
    step(1'b0, 8'h00, 2, 8'hFF, 1'b0, 300);
    step(1'b0, 8'h00, 2, 8'hFF, 1'b0, 301);

    // reset while in EXTBRK; next byte decodes from IDLE
    step(1'b1, 8'h1C, 2, 8'hFF, 1'b0, 310);
    step(1'b1, 8'hE0, 2, 8'hFB, 1'b1, 311);
    step(1'b1, 8'hF0, 2, 8'hFB, 1'b1, 312);
    reset = 1'b0;
    step(1'b0, 8'h00, 2, 8'hFF, 1'b0, 313);
    reset = 1'b1;
    step(1'b0, 8'h00, 2, 8'hFF, 1'b0, 314);
    step(1'b1, 8'h1C, 2, 8'hFF, 1'b0, 315);
    step(1'b0, 8'h00, 2, 8'hFB, 1'b1, 316);
    step(1'b1, 8'hF0, 2, 8'hFB, 1'b1, 317);
    step(1'b1, 8'h1C, 2, 8'hFB, 1'b1, 318);
    step(1'b0, 8'h00, 2, 8'hFF, 1'b0, 319);

    // reset while in SKIP; space right after is a real make
    step(1'b1, 8'hE1, 9, 8'hFF, 1'b0, 320);
    step(1'b1, 8'h14, 9, 8'hFF, 1'b0, 321);
    reset = 1'b0;
    step(1'b0, 8'h00, 9, 8'hFF, 1'b0, 322);
    reset = 1'b1;
    step(1'b1, 8'h29, 9, 8'hFF, 1'b0, 323);
    step(1'b0, 8'h00, 9, 8'hF7, 1'b1, 324);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
